// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command driver: command word layout, opcodes,
// idle pin pattern and driver state encoding.
package alsu_pkg;

  localparam int unsigned CmdW = 16;

  localparam int unsigned CmdAHi       = 15;
  localparam int unsigned CmdALo       = 13;
  localparam int unsigned CmdBHi       = 12;
  localparam int unsigned CmdBLo       = 10;
  localparam int unsigned CmdOpHi      = 9;
  localparam int unsigned CmdOpLo      = 7;
  localparam int unsigned CmdCin       = 6;
  localparam int unsigned CmdSerialIn  = 5;
  localparam int unsigned CmdRedOpA    = 4;
  localparam int unsigned CmdRedOpB    = 3;
  localparam int unsigned CmdBypassA   = 2;
  localparam int unsigned CmdBypassB   = 1;
  localparam int unsigned CmdDirection = 0;

  localparam logic [2:0] OpAnd    = 3'b000;
  localparam logic [2:0] OpXor    = 3'b001;
  localparam logic [2:0] OpAdd    = 3'b010;
  localparam logic [2:0] OpMul    = 3'b011;
  localparam logic [2:0] OpShift  = 3'b100;
  localparam logic [2:0] OpRotate = 3'b101;
  localparam logic [2:0] OpInv6   = 3'b110;
  localparam logic [2:0] OpInv7   = 3'b111;

  // Idle pattern: every field zero except the opcode, which must hold ALSU out.
  function automatic logic [CmdW-1:0] idle_word(input logic [2:0] op);
    logic [CmdW-1:0] w;
    w = '0;
    w[CmdOpHi:CmdOpLo] = op;
    return w;
  endfunction

  localparam logic [CmdW-1:0] IdlePattern = idle_word(OpInv6);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCapOut,
    StCapLed,
    StResp
  } drv_state_e;

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read data.
module alsu_cmd_fifo
  import alsu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [CmdW-1:0] wdata,
  input  logic            pop,
  output logic [CmdW-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CmdW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alsu_cmd_driver.sv
// Buffers ALSU commands, drives the ALSU pins for one cycle per command and
// returns the captured out/leds result on a valid/ready response stream.
module alsu_cmd_driver
  import alsu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [2:0]  IDLE_OPCODE = 3'b110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_out,
  output logic        rsp_invalid,
  output logic        rsp_leds_bad,
  output logic        busy,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  output logic        alsu_direction,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds
);

  localparam logic [CmdW-1:0] IdleWord = idle_word(IDLE_OPCODE);

  drv_state_e      state_q, state_d;
  logic [CmdW-1:0] pins_q, pins_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [5:0]      rsp_out_q, rsp_out_d;
  logic            rsp_invalid_q, rsp_invalid_d;
  logic            rsp_leds_bad_q, rsp_leds_bad_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CmdW-1:0] fifo_rdata;

  assign cmd_ready = ~rst & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;

  alsu_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(cmd_data),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    pins_d         = pins_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_out_d      = rsp_out_q;
    rsp_invalid_d  = rsp_invalid_q;
    rsp_leds_bad_d = rsp_leds_bad_q;
    fifo_pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pins_d   = fifo_rdata;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        pins_d  = IdleWord;
        state_d = StWait;
      end
      StWait: state_d = StCapOut;
      StCapOut: begin
        rsp_out_d = alsu_out;
        state_d   = StCapLed;
      end
      StCapLed: begin
        rsp_invalid_d  = (alsu_leds == 16'hFFFF);
        rsp_leds_bad_d = (alsu_leds != 16'h0000) && (alsu_leds != 16'hFFFF);
        rsp_valid_d    = 1'b1;
        state_d        = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            pins_d   = fifo_rdata;
            state_d  = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pins_q         <= IdleWord;
      rsp_valid_q    <= 1'b0;
      rsp_out_q      <= '0;
      rsp_invalid_q  <= 1'b0;
      rsp_leds_bad_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pins_q         <= pins_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_out_q      <= rsp_out_d;
      rsp_invalid_q  <= rsp_invalid_d;
      rsp_leds_bad_q <= rsp_leds_bad_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_out        = rsp_out_q;
  assign rsp_invalid    = rsp_invalid_q;
  assign rsp_leds_bad   = rsp_leds_bad_q;
  assign busy           = (state_q != StIdle) | ~fifo_empty;

  assign alsu_A         = pins_q[CmdAHi:CmdALo];
  assign alsu_B         = pins_q[CmdBHi:CmdBLo];
  assign alsu_opcode    = pins_q[CmdOpHi:CmdOpLo];
  assign alsu_cin       = pins_q[CmdCin];
  assign alsu_serial_in = pins_q[CmdSerialIn];
  assign alsu_red_op_A  = pins_q[CmdRedOpA];
  assign alsu_red_op_B  = pins_q[CmdRedOpB];
  assign alsu_bypass_A  = pins_q[CmdBypassA];
  assign alsu_bypass_B  = pins_q[CmdBypassB];
  assign alsu_direction = pins_q[CmdDirection];

endmodule

// File: doc/alsu_cmd_driver.md
# alsu_cmd_driver

Command-side initiator for the ALSU. It accepts packed 16-bit operation commands over a valid/ready stream and buffers them in a small FIFO. It then drives the ALSU input pins for exactly one cycle per command, waits out the ALSU's register pipeline, and captures `out` and the `leds` error indication. The result comes back on a valid/ready response stream. It sits between the host/test sequencer and one ALSU instance, both on the same `clk`/`rst`.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `IDLE_OPCODE`, 3'b110: opcode driven between commands. Leaves ALSU `out` unchanged.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `cmd_valid` in 1: command word present.
- `cmd_ready` out 1: FIFO not full; 0 while `rst` is high.
- `cmd_data` in 16: fields, listed from bit 15 down to bit 0:
  - [15:13] A, [12:10] B, [9:7] opcode
  - [6] cin, [5] serial_in, [4] red_op_A, [3] red_op_B
  - [2] bypass_A, [1] bypass_B, [0] direction
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_out` out 6: captured ALSU `out`.
- `rsp_invalid` out 1: captured `leds == 16'hFFFF`.
- `rsp_leds_bad` out 1: captured `leds` is neither 0 nor 16'hFFFF.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `alsu_A`, `alsu_B`, `alsu_opcode` out 3 each: to ALSU.
- `alsu_cin`, `alsu_serial_in`, `alsu_red_op_A`, `alsu_red_op_B`, `alsu_bypass_A`, `alsu_bypass_B`, `alsu_direction` out 1 each: to ALSU.
- `alsu_out` in 6: from ALSU.
- `alsu_leds` in 16: from ALSU.

## Operation
- **Push rule:** `cmd_valid & cmd_ready` pushes on the edge. Push and pop on the same edge are allowed, and the count is unchanged. No push when full. No pop when empty.
- **Pins:** all `alsu_*` outputs are registered. Outside DRIVE they carry the idle pattern: opcode = `IDLE_OPCODE`, all other fields 0. The idle pattern preserves `out`, so shift and rotate chain correctly across commands. ALSU `leds` reads all-ones while idle; this is expected.
- **One command in flight.** States:
  - IDLE: if FIFO non-empty, pop, load pins ← head, go to DRIVE.
  - DRIVE: pins ← idle pattern; go to WAIT.
  - WAIT: go to CAP_OUT.
  - CAP_OUT: `rsp_out` ← `alsu_out`; go to CAP_LED.
  - CAP_LED: `rsp_invalid`, `rsp_leds_bad` ← decode of `alsu_leds`; set `rsp_valid`; go to RESP.
  - RESP: on `rsp_ready`, clear `rsp_valid`. If the FIFO is non-empty, pop, load pins, go to DRIVE; otherwise go to IDLE.
- **Response fields:** stable while `rsp_valid` is high.
- **No arithmetic:** the block does no arithmetic. It packs and unpacks fields only.

## Timing
- **Reset values:** `cmd_ready`=0 during `rst`, 1 after. `rsp_valid`=0, `rsp_out`=0, `rsp_invalid`=0, `rsp_leds_bad`=0, `busy`=0. Pins = idle pattern. FIFO emptied. State = IDLE.
- **Latency from acceptance edge E, empty and idle:**
  - Pins carry the command from E+1 to E+2 (exactly one cycle).
  - `out` is sampled at E+4 and `leds` at E+5.
  - `rsp_valid` is high from E+5.
- **Throughput:** back-to-back commands with `rsp_ready` held high issue every 5 cycles.
- **Back-pressure:** the state machine stalls in RESP indefinitely. Pins stay idle, so `out` is preserved.
- **Reset mid-operation:** the in-flight command and the FIFO contents are discarded. No response is produced for them.

## Structure
- **Package `alsu_pkg`:**
  - command field bit-position localparams
  - opcode constants: AND, XOR, ADD, MUL, SHIFT, ROTATE, INV6, INV7
  - the idle pattern
  - the state enum
- **Sub-module `alsu_cmd_fifo`:** synchronous FIFO, 16-bit wide, `FIFO_DEPTH` entries, with `full`/`empty`, and a count width of $clog2(`FIFO_DEPTH`)+1.

## Test plan
All scenarios use an ALSU with priority "A" and full adder "ON".
1. **ADD:** push A=3, B=5, op=010, cin=1 → `rsp_out`=9, `rsp_invalid`=0, `rsp_valid` rising 5 cycles after acceptance.
2. **Chained shift/rotate:**
   - bypass_A with A=5 → `rsp_out`=5.
   - op=100, direction=1, serial_in=1 → 11.
   - op=101, direction=0 → 37.
3. **MUL:** push A=7, B=7, op=011 → 49.
4. **Invalid:**
   - op=010 with red_op_A=1 → `rsp_out`=0, `rsp_invalid`=1.
   - Then op=111 → `rsp_invalid`=1, `rsp_out`=0 (unchanged).
5. **Back-pressure:** hold `rsp_ready`=0 and push 6 commands. `cmd_ready` falls after 5 accepts. Release → 5 responses in order, spaced 5 cycles apart.
6. **Reset mid-operation:** assert `rst` during WAIT with 2 commands queued → `rsp_valid`=0, `busy`=0 after reset, and no stale response ever appears.
